branch_history_controller: RTL and testbench

Tracks in-flight conditional branches between fetch-time prediction and execute-time resolution for the global predictor. It owns the speculative global history register (GHR) used to index the pattern history table (PHT) and queues a snapshot per predicted branch. It sequences exactly one saturating-counter update per resolved branch to the PHT, using a valid/ready handshake. It repairs the history and flushes younger entries on a misprediction.

---
 rtl/branch_history_controller.sv | 130 +++++++++++++
 tb/tb_branch_history_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_controller.sv
// In-flight conditional branch tracker for the global predictor:
// owns the speculative GHR, queues snapshots, sequences PHT updates.
module branch_history_controller #(
    parameter int GHR_W = 12,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       pred_valid,
    input  logic [31:0]                pred_pc,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    output logic [GHR_W-1:0]           ghr,
    input  logic                       res_valid,
    input  logic [31:0]                res_pc,
    input  logic                       res_taken,
    output logic                       res_ready,
    output logic                       pht_upd_valid,
    output logic [GHR_W-1:0]           pht_upd_idx,
    output logic                       pht_upd_taken,
    input  logic                       pht_upd_ready,
    output logic                       mispredict,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       err_order
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef enum logic {
        NORMAL,
        RECOVER
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [31:0]      r_pc   [DEPTH];
    logic [GHR_W-1:0] r_snap [DEPTH];
    logic [DEPTH-1:0] r_pred;

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [OW-1:0]    r_occ;
    logic [GHR_W-1:0] r_ghr;
    logic             r_upd_valid;
    logic [GHR_W-1:0] r_upd_idx;
    logic             r_upd_taken;
    logic             r_err;

    logic w_push;
    logic w_res;
    logic w_empty;
    logic w_pop;
    logic w_mis;
    logic w_wr;

    assign pred_ready = (r_occ < OW'(DEPTH)) && (r_state == NORMAL);
    assign res_ready  = !r_upd_valid || pht_upd_ready;

    assign w_push  = pred_valid && pred_ready;
    assign w_res   = res_valid && res_ready;
    assign w_empty = (r_occ == '0);
    assign w_pop   = w_res && !w_empty;
    assign w_mis   = w_pop && (res_taken != r_pred[r_head]);
    // A push racing a misprediction is on the wrong path.
    assign w_wr    = w_push && !w_mis;

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            NORMAL:  if (w_mis) w_state_nx = RECOVER;
            RECOVER: w_state_nx = NORMAL;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= NORMAL;
            r_head      <= '0;
            r_tail      <= '0;
            r_occ       <= '0;
            r_ghr       <= '0;
            r_upd_valid <= 1'b0;
            r_upd_idx   <= '0;
            r_upd_taken <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_mis) begin
                r_occ  <= '0;
                r_head <= r_head + 1'b1;
                r_tail <= r_head + 1'b1;
                r_ghr  <= {r_snap[r_head][GHR_W-2:0], res_taken};
            end else begin
                if (w_wr) begin
                    r_tail <= r_tail + 1'b1;
                    r_ghr  <= {r_ghr[GHR_W-2:0], pred_taken};
                end
                if (w_pop) r_head <= r_head + 1'b1;
                r_occ <= r_occ + OW'(w_wr) - OW'(w_pop);
            end
            if (w_pop) begin
                r_upd_valid <= 1'b1;
                r_upd_idx   <= r_snap[r_head];
                r_upd_taken <= res_taken;
            end else if (pht_upd_ready) begin
                r_upd_valid <= 1'b0;
            end
            if (w_res && (w_empty || (res_pc != r_pc[r_head]))) r_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_pc[r_tail]   <= pred_pc;
            r_snap[r_tail] <= r_ghr;
            r_pred[r_tail] <= pred_taken;
        end
    end

    assign ghr           = r_ghr;
    assign occupancy     = r_occ;
    assign pht_upd_valid = r_upd_valid;
    assign pht_upd_idx   = r_upd_idx;
    assign pht_upd_taken = r_upd_taken;
    assign mispredict    = (r_state == RECOVER);
    assign err_order     = r_err;

endmodule

// File: tb/tb_branch_history_controller.sv
// Directed bench with a reference queue model and a PHT update
// scoreboard for branch_history_controller.
module tb_branch_history_controller;

    localparam int GHR_W = 12;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH + 1);

    logic             CLK;
    logic             RESET;
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             pred_ready;
    logic [GHR_W-1:0] ghr;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic             res_taken;
    logic             res_ready;
    logic             pht_upd_valid;
    logic [GHR_W-1:0] pht_upd_idx;
    logic             pht_upd_taken;
    logic             pht_upd_ready;
    logic             mispredict;
    logic [OW-1:0]    occupancy;
    logic             err_order;

    branch_history_controller #(
        .GHR_W(GHR_W),
        .DEPTH(DEPTH)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .pred_valid   (pred_valid),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .pred_ready   (pred_ready),
        .ghr          (ghr),
        .res_valid    (res_valid),
        .res_pc       (res_pc),
        .res_taken    (res_taken),
        .res_ready    (res_ready),
        .pht_upd_valid(pht_upd_valid),
        .pht_upd_idx  (pht_upd_idx),
        .pht_upd_taken(pht_upd_taken),
        .pht_upd_ready(pht_upd_ready),
        .mispredict   (mispredict),
        .occupancy    (occupancy),
        .err_order    (err_order)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]      pc;
        logic [GHR_W-1:0] snap;
        logic             pred;
    } ent_t;

    typedef struct {
        logic [GHR_W-1:0] idx;
        logic             tk;
    } upd_t;

    ent_t             mq[$];
    upd_t             sb[$];
    logic [GHR_W-1:0] m_ghr;
    logic             m_rec;
    logic             m_uv;
    logic             m_err;
    int               n_cmp;
    int               n_fail;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        m_ghr = '0;
        m_rec = 1'b0;
        m_uv  = 1'b0;
        m_err = 1'b0;
    endtask

    // Asynchronous reset: outputs must be at reset values before any edge.
    task automatic do_reset();
        RESET      = 1'b1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        #1;
        chk("rst_ghr", 32'(ghr), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_pred_ready", 32'(pred_ready), 1);
        chk("rst_res_ready", 32'(res_ready), 1);
        chk("rst_upd_valid", 32'(pht_upd_valid), 0);
        chk("rst_upd_idx", 32'(pht_upd_idx), 0);
        chk("rst_upd_taken", 32'(pht_upd_taken), 0);
        chk("rst_mispredict", 32'(mispredict), 0);
        chk("rst_err", 32'(err_order), 0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic step(input logic pv, input logic [31:0] ppc,
                        input logic pt, input logic rv,
                        input logic [31:0] rpc, input logic rt,
                        input logic ur);
        ent_t h;
        logic epr;
        logic err_rdy;
        logic push;
        logic res;
        logic mis;
        logic unx;
        pred_valid    = pv;
        pred_pc       = ppc;
        pred_taken    = pt;
        res_valid     = rv;
        res_pc        = rpc;
        res_taken     = rt;
        pht_upd_ready = ur;
        #1;
        epr     = (mq.size() < DEPTH) && !m_rec;
        err_rdy = !m_uv || ur;
        chk("pred_ready", 32'(pred_ready), 32'(epr));
        chk("res_ready", 32'(res_ready), 32'(err_rdy));
        chk("ghr", 32'(ghr), 32'(m_ghr));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("mispredict", 32'(mispredict), 32'(m_rec));
        chk("err_order", 32'(err_order), 32'(m_err));
        chk("upd_valid", 32'(pht_upd_valid), 32'(m_uv));
        if (m_uv && sb.size() > 0) begin
            chk("upd_idx", 32'(pht_upd_idx), 32'(sb[0].idx));
            chk("upd_taken", 32'(pht_upd_taken), 32'(sb[0].tk));
            if (ur) void'(sb.pop_front());
        end
        push = pv && epr;
        res  = rv && err_rdy;
        mis  = 1'b0;
        unx  = m_uv && !ur;
        h    = '{32'h0, '0, 1'b0};
        if (res) begin
            if (mq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                h = mq.pop_front();
                if (h.pc != rpc) m_err = 1'b1;
                sb.push_back('{h.snap, rt});
                unx = 1'b1;
                mis = (rt != h.pred);
            end
        end
        if (mis) begin
            mq.delete();
            m_ghr = {h.snap[GHR_W-2:0], rt};
        end else if (push) begin
            mq.push_back('{ppc, m_ghr, pt});
            m_ghr = {m_ghr[GHR_W-2:0], pt};
        end
        m_rec = mis;
        m_uv  = unx;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [31:0] pc, input logic t);
        step(1'b1, pc, t, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t);
        step(1'b0, 32'h0, 1'b0, 1'b1, pc, t, 1'b1);
    endtask

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        pred_pc       = '0;
        pred_taken    = 1'b0;
        res_pc        = '0;
        res_taken     = 1'b0;
        pht_upd_ready = 1'b1;
        do_reset();

        push(32'h100, 1'b1);
        push(32'h104, 1'b0);
        chk("ghr_two_push", 32'(ghr), 32'h002);
        chk("occ_two_push", 32'(occupancy), 2);
        resolve(32'h100, 1'b1);
        resolve(32'h104, 1'b0);
        chk("upd2_idx", 32'(pht_upd_idx), 32'h001);
        chk("upd2_taken", 32'(pht_upd_taken), 0);
        idle();
        idle();
        chk("occ_drained", 32'(occupancy), 0);

        for (int i = 0; i < DEPTH; i++)
            push(32'h200 + 32'(4 * i), (i != 2));
        step(1'b1, 32'h210, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("full_occ", 32'(occupancy), 4);
        chk("full_pred_ready", 32'(pred_ready), 0);
        step(1'b1, 32'h210, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b1, 32'h210, 1'b1, 1'b1, 32'h204, 1'b1, 1'b1);
        chk("push_pop_occ", 32'(occupancy), 3);
        push(32'h214, 1'b0);
        chk("refill_occ", 32'(occupancy), 4);
        while (mq.size() > 0) resolve(mq[0].pc, mq[0].pred);
        idle();
        idle();

        do_reset();
        push(32'h300, 1'b1);
        push(32'h304, 1'b1);
        push(32'h308, 1'b0);
        step(1'b1, 32'h30C, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
        chk("mis_high", 32'(mispredict), 1);
        chk("mis_ghr", 32'(ghr), 32'h000);
        chk("mis_pred_ready", 32'(pred_ready), 0);
        step(1'b1, 32'h310, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("mis_low", 32'(mispredict), 0);
        chk("mis_dropped_occ", 32'(occupancy), 0);
        idle();

        push(32'h400, 1'b1);
        step(1'b1, 32'h404, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h404, 1'b0, 1'b0);
        chk("stall_res_ready", 32'(res_ready), 0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h404, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h404, 1'b0, 1'b1);
        idle();
        idle();

        resolve(32'h500, 1'b1);
        chk("err_empty", 32'(err_order), 1);
        push(32'h600, 1'b1);
        resolve(32'h604, 1'b1);
        idle();
        chk("err_sticky", 32'(err_order), 1);
        push(32'h700, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h700, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_reset();
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
